rr_arbiter_n: RTL and testbench

RR_ARBITER_N -- requirements
Module: rr_arbiter_n

---
 rtl/rr_arbiter_n.sv | 134 +++++++++++++
 tb/tb_rr_arbiter_n.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_n
//  Description : N-way arbiter with fixed-priority or round-robin selection,
//                registered one-hot grant, ACK / request-drop release and an
//                optional hold timeout with a one-cycle timeout pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter_n #(
    parameter int N       = 4,
    parameter int MODE    = 1,
    parameter int TIMEOUT = 15,
    parameter int IDW     = $clog2(N)
) (
    input  logic           i_clk,
    input  logic           i_sclr,
    input  logic [N-1:0]   i_req,
    input  logic           i_ack,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_grant_id,
    output logic           o_busy,
    output logic           o_timeout_flag
);

    localparam logic [0:0]     c_S_IDLE    = 1'b0;
    localparam logic [0:0]     c_S_OWNED   = 1'b1;
    localparam bit             c_TO_EN     = (TIMEOUT != 0);
    // Hold count value at which the owner has used up its TIMEOUT cycles.
    localparam logic [7:0]     c_HOLD_LAST = c_TO_EN ? 8'(TIMEOUT - 1) : 8'd0;
    localparam logic [7:0]     c_HOLD_MAX  = 8'hFF;
    localparam logic [IDW-1:0] c_LAST_RST  = IDW'(N - 1);
    localparam logic [N-1:0]   c_ONE       = {{(N-1){1'b0}}, 1'b1};

    logic [0:0]     r_state;
    logic [N-1:0]   r_grant;
    logic [IDW-1:0] r_grant_id;
    logic [IDW-1:0] r_last;
    logic [7:0]     r_hold_cnt;
    logic           r_timeout_flag;

    logic [0:0]     w_state_nxt;
    logic           w_owner_req;
    logic           w_rel_user;
    logic           w_hit_limit;
    logic           w_release;
    logic           w_req_any;
    int             w_start;
    logic [2*N-1:0] w_req2;
    logic [N-1:0]   w_rot;
    logic [N-1:0]   w_shift;
    logic           w_found;
    logic [IDW-1:0] w_winner;

    // State register plus all registered datapath (grant, owner, LAST, hold count, flag).
    always_ff @(posedge i_clk) begin
        if (i_sclr) begin
            r_state        <= c_S_IDLE;
            r_grant        <= '0;
            r_grant_id     <= '0;
            r_last         <= c_LAST_RST;
            r_hold_cnt     <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_timeout_flag <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_req_any) begin
                        r_grant    <= c_ONE << w_winner;
                        r_grant_id <= w_winner;
                        r_last     <= w_winner;
                        r_hold_cnt <= '0;
                    end
                end
                c_S_OWNED: begin
                    if (w_release) begin
                        r_grant        <= '0;
                        r_grant_id     <= '0;
                        // Only a pure timeout release raises the flag.
                        r_timeout_flag <= !w_rel_user;
                    end else if (r_hold_cnt != c_HOLD_MAX) begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: begin
                    r_grant    <= '0;
                    r_grant_id <= '0;
                end
            endcase
        end
    end

    // Next-state logic: release detection while owned, request detection while idle.
    always_comb begin
        w_req_any   = |i_req;
        w_owner_req = |(i_req & r_grant);
        w_rel_user  = i_ack || !w_owner_req;
        w_hit_limit = c_TO_EN && (r_hold_cnt == c_HOLD_LAST);
        w_release   = w_rel_user || w_hit_limit;
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (w_req_any) w_state_nxt = c_S_OWNED;
            c_S_OWNED: if (w_release) w_state_nxt = c_S_IDLE;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    // Winner search: rotate requests so the search origin sits at bit 0, take the first set bit.
    always_comb begin
        w_start  = (MODE == 1) ? ((int'(r_last) + 1) % N) : 0;
        w_req2   = {i_req, i_req} >> w_start;
        w_rot    = w_req2[N-1:0];
        w_shift  = '0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < N; i++) begin
            w_shift = w_rot >> i;
            if (!w_found && w_shift[0]) begin
                w_found  = 1'b1;
                w_winner = IDW'((w_start + i) % N);
            end
        end
    end

    // Outputs come straight from registers; BUSY mirrors a non-empty grant.
    always_comb begin
        o_grant        = r_grant;
        o_grant_id     = r_grant_id;
        o_busy         = |r_grant;
        o_timeout_flag = r_timeout_flag;
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter_n
//  Description : Self-checking bench for rr_arbiter_n. Five configurations
//                share one stimulus stream; a behavioural model tracks the
//                owner of each and every output is compared each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_arbiter_n;

    logic        clk = 1'b0;
    logic        sclr;
    logic [15:0] req;
    logic        ack;

    logic [3:0] g0, g1, g2;
    logic [1:0] id0, id1, id2;
    logic       b0, b1, b2, f0, f1, f2;
    logic [7:0] g3;
    logic [2:0] id3;
    logic       b3, f3;
    logic [2:0] g4;
    logic [1:0] id4;
    logic       b4, f4;

    int n_checks = 0;
    int n_fail   = 0;

    int m_own  [5];
    int m_last [5];
    int m_age  [5];
    int m_flag [5];

    always #5 clk = ~clk;

    rr_arbiter_n #(.N(4), .MODE(1), .TIMEOUT(15)) u0 (
        .i_clk(clk), .i_sclr(sclr), .i_req(req[3:0]), .i_ack(ack),
        .o_grant(g0), .o_grant_id(id0), .o_busy(b0), .o_timeout_flag(f0));
    rr_arbiter_n #(.N(4), .MODE(0), .TIMEOUT(15)) u1 (
        .i_clk(clk), .i_sclr(sclr), .i_req(req[3:0]), .i_ack(ack),
        .o_grant(g1), .o_grant_id(id1), .o_busy(b1), .o_timeout_flag(f1));
    rr_arbiter_n #(.N(4), .MODE(1), .TIMEOUT(3)) u2 (
        .i_clk(clk), .i_sclr(sclr), .i_req(req[3:0]), .i_ack(ack),
        .o_grant(g2), .o_grant_id(id2), .o_busy(b2), .o_timeout_flag(f2));
    rr_arbiter_n #(.N(8), .MODE(1), .TIMEOUT(5)) u3 (
        .i_clk(clk), .i_sclr(sclr), .i_req(req[7:0]), .i_ack(ack),
        .o_grant(g3), .o_grant_id(id3), .o_busy(b3), .o_timeout_flag(f3));
    rr_arbiter_n #(.N(3), .MODE(1), .TIMEOUT(0)) u4 (
        .i_clk(clk), .i_sclr(sclr), .i_req(req[2:0]), .i_ack(ack),
        .o_grant(g4), .o_grant_id(id4), .o_busy(b4), .o_timeout_flag(f4));

    function automatic int p_n(input int k);
        case (k)
            3:       return 8;
            4:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int p_mode(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    function automatic int p_to(input int k);
        case (k)
            2:       return 3;
            3:       return 5;
            4:       return 0;
            default: return 15;
        endcase
    endfunction

    function automatic int unsigned dut_g(input int k);
        case (k)
            0:       return 32'(g0);
            1:       return 32'(g1);
            2:       return 32'(g2);
            3:       return 32'(g3);
            default: return 32'(g4);
        endcase
    endfunction

    function automatic int unsigned dut_id(input int k);
        case (k)
            0:       return 32'(id0);
            1:       return 32'(id1);
            2:       return 32'(id2);
            3:       return 32'(id3);
            default: return 32'(id4);
        endcase
    endfunction

    function automatic int unsigned dut_b(input int k);
        case (k)
            0:       return 32'(b0);
            1:       return 32'(b1);
            2:       return 32'(b2);
            3:       return 32'(b3);
            default: return 32'(b4);
        endcase
    endfunction

    function automatic int unsigned dut_f(input int k);
        case (k)
            0:       return 32'(f0);
            1:       return 32'(f1);
            2:       return 32'(f2);
            3:       return 32'(f3);
            default: return 32'(f4);
        endcase
    endfunction

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // First requester found walking upward from the search origin.
    function automatic int pick(input int k, input logic [15:0] r);
        int n;
        int start;
        int idx;
        logic [15:0] s;
        n     = p_n(k);
        start = (p_mode(k) == 1) ? (m_last[k] + 1) % n : 0;
        for (int i = 0; i < n; i++) begin
            idx = (start + i) % n;
            s   = r >> idx;
            if (s[0]) return idx;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge given the inputs present at that edge.
    task automatic model_step(input logic s, input logic [15:0] r_in, input logic a);
        logic [15:0] r;
        logic [15:0] o;
        int          w;
        for (int k = 0; k < 5; k++) begin
            r = r_in & ((16'h1 << p_n(k)) - 16'h1);
            if (s) begin
                m_own[k]  = -1;
                m_last[k] = p_n(k) - 1;
                m_age[k]  = 0;
                m_flag[k] = 0;
            end else if (m_own[k] < 0) begin
                m_flag[k] = 0;
                w = pick(k, r);
                if (w >= 0) begin
                    m_own[k]  = w;
                    m_last[k] = w;
                    m_age[k]  = 0;
                end
            end else begin
                m_age[k] = m_age[k] + 1;
                o = r >> m_own[k];
                if (a || !o[0]) begin
                    m_own[k]  = -1;
                    m_flag[k] = 0;
                end else if (p_to(k) != 0 && m_age[k] >= p_to(k)) begin
                    m_own[k]  = -1;
                    m_flag[k] = 1;
                end else begin
                    m_flag[k] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        int unsigned eg;
        int unsigned ei;
        for (int k = 0; k < 5; k++) begin
            eg = (m_own[k] < 0) ? 0 : (32'd1 << m_own[k]);
            ei = (m_own[k] < 0) ? 0 : 32'(m_own[k]);
            chk($sformatf("u%0d_grant", k), dut_g(k), eg);
            chk($sformatf("u%0d_grant_id", k), dut_id(k), ei);
            chk($sformatf("u%0d_busy", k), dut_b(k), (m_own[k] < 0) ? 0 : 1);
            chk($sformatf("u%0d_timeout_flag", k), dut_f(k), 32'(m_flag[k]));
            chk($sformatf("u%0d_onehot0", k), 32'($onehot0(dut_g(k))), 1);
        end
    endtask

    task automatic cycle(input logic s, input logic [15:0] r, input logic a);
        sclr = s;
        req  = r;
        ack  = a;
        model_step(s, r, a);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        cycle(1'b1, 16'h0, 1'b0);
        cycle(1'b1, 16'h0, 1'b0);
    endtask

    initial begin
        sclr = 1'b1;
        req  = '0;
        ack  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            m_own[k]  = -1;
            m_last[k] = p_n(k) - 1;
            m_age[k]  = 0;
            m_flag[k] = 0;
        end

        // Reset state
        do_reset();
        for (int k = 0; k < 5; k++) begin
            chk("rst_grant", dut_g(k), 0);
            chk("rst_id", dut_id(k), 0);
            chk("rst_busy", dut_b(k), 0);
            chk("rst_flag", dut_f(k), 0);
        end

        // Round-robin rotation with ACK every second cycle
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 16'hF, (i % 2) == 1);
            chk("rr_sequence", dut_g(0), (i % 2 == 0) ? (32'd1 << ((i / 2) % 4)) : 0);
        end

        // Fixed priority: requester 1 always beats requester 3
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 16'hA, (i % 2) == 1);
            chk("fixed_prio", dut_g(1), (i % 2 == 0) ? 32'h2 : 0);
        end

        // Timeout of 3 cycles with held request and no ACK
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 16'h4, 1'b0);
            chk("timeout_grant", dut_g(2), (i == 3) ? 0 : 32'h4);
            chk("timeout_flag", dut_f(2), (i == 3) ? 1 : 0);
        end

        // Owner drops its request
        do_reset();
        cycle(1'b0, 16'h4, 1'b0);
        chk("drop_granted", dut_g(0), 32'h4);
        cycle(1'b0, 16'h0, 1'b0);
        chk("drop_release", dut_g(0), 0);
        chk("drop_noflag", dut_f(0), 0);
        cycle(1'b0, 16'h8, 1'b0);
        chk("drop_next", dut_g(0), 32'h8);

        // Reset mid-grant, held reset, then first grant restarts at index 0
        do_reset();
        cycle(1'b0, 16'h4, 1'b0);
        chk("sclr_pre", dut_g(0), 32'h4);
        cycle(1'b1, 16'hF, 1'b0);
        chk("sclr_grant", dut_g(0), 0);
        chk("sclr_id", dut_id(0), 0);
        chk("sclr_busy", dut_b(0), 0);
        chk("sclr_flag", dut_f(0), 0);
        cycle(1'b1, 16'hF, 1'b1);
        chk("sclr_held", dut_g(0), 0);
        cycle(1'b0, 16'hF, 1'b0);
        chk("sclr_first", dut_g(0), 32'h1);

        // Randomized traffic with slowly changing requests
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] flip;
            flip = 16'($urandom) & 16'($urandom) & 16'($urandom);
            cycle($urandom_range(0, 199) == 0, req ^ flip, $urandom_range(0, 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
